// File: rtl/io_regs_pkg.sv
// io_regs_pkg: shared I/O bus register map for the keyboard FIFO slave.
// Register indices, STATUS bit positions and CTRL bit positions.
package io_regs_pkg;

    typedef enum logic [1:0] {
        KB_REG_DATA   = 2'd0,
        KB_REG_STATUS = 2'd1,
        KB_REG_CTRL   = 2'd2,
        KB_REG_RSVD   = 2'd3
    } kb_reg_e;

    localparam int KB_ST_EMPTY = 16;
    localparam int KB_ST_FULL  = 17;
    localparam int KB_ST_OVF   = 18;

    localparam int KB_CTRL_FLUSH  = 0;
    localparam int KB_CTRL_CLROVF = 1;
    localparam int KB_CTRL_IRQEN  = 2;

endpackage

// File: rtl/wb_kb_fifo_if.sv
// wb_kb_fifo_if: Wishbone classic bus bundle for the keyboard FIFO slave.
// Signal names keep the slave-side _i/_o suffixes.
interface wb_kb_fifo_if;

    logic [1:0]  adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        we_i;
    logic [3:0]  sel_i;
    logic        stb_i;
    logic        cyc_i;
    logic        ack_o;

    modport master (
        output adr_i, dat_i, we_i, sel_i, stb_i, cyc_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  adr_i, dat_i, we_i, sel_i, stb_i, cyc_i,
        output dat_o, ack_o
    );

endinterface

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO, register-array storage, combinational head.
// Caller guarantees no push when full and no pop when empty.
module fifo_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full
);

    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] r_wp;
    logic [DEPTH_LOG2-1:0] r_rp;
    logic [CW-1:0]         r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (push) r_wp <= r_wp + DEPTH_LOG2'(1);
            if (pop)  r_rp <= r_rp + DEPTH_LOG2'(1);
            r_cnt <= r_cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_wp] <= din;
    end

    assign dout  = r_mem[r_rp];
    assign count = r_cnt;
    assign empty = (r_cnt == '0);
    assign full  = (r_cnt == FULL_CNT);

endmodule

// File: rtl/wb_kb_fifo.sv
// wb_kb_fifo: Wishbone slave buffering PS/2 scan codes (DATA/STATUS/CTRL).
// Define WB_KB_FIFO_IRQ_EN to add the registered irq output.
module wb_kb_fifo
    import io_regs_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wb_kb_fifo_if.slave           wb,
    input  logic [DATA_WIDTH-1:0] kb_data,
    input  logic                  kb_valid,
`ifdef WB_KB_FIFO_IRQ_EN
    output logic                  irq,
`endif
    output logic                  kb_ready
);

    localparam int CW = DEPTH_LOG2 + 1;

    logic [DATA_WIDTH-1:0] w_head;
    logic [CW-1:0]         w_count;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_req;
    logic                  w_rd;
    logic                  w_ctrl_wr;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_flush;
    logic                  w_clrovf;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    logic                  r_ack;
    logic [31:0]           r_dat;
    logic                  r_ovf;
`ifdef WB_KB_FIFO_IRQ_EN
    logic                  r_irq_en;
    logic                  r_irq;
`endif

    assign w_req     = wb.cyc_i & wb.stb_i & ~r_ack;
    assign w_rd      = w_req & ~wb.we_i;
    assign w_ctrl_wr = w_req & wb.we_i & wb.sel_i[0]
                     & (wb.adr_i == KB_REG_CTRL);
    assign w_flush   = w_ctrl_wr & wb.dat_i[KB_CTRL_FLUSH];
    assign w_clrovf  = w_ctrl_wr & wb.dat_i[KB_CTRL_CLROVF];
    assign w_pop     = w_rd & ~w_empty & (wb.adr_i == KB_REG_DATA);

    // A flush swallows any push landing in the same cycle, without overflow.
    assign kb_ready  = ~w_full;
    assign w_push    = kb_valid & ~w_full & ~w_flush;
    assign w_drop    = kb_valid & w_full & ~w_flush;

    assign w_unused  = &{1'b0, wb.dat_i, wb.sel_i};

    fifo_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (kb_data),
        .dout  (w_head),
        .count (w_count),
        .empty (w_empty),
        .full  (w_full)
    );

    always_comb begin
        w_rdata = '0;
        unique case (1'b1)
            (wb.adr_i == KB_REG_DATA): begin
                if (!w_empty) w_rdata[DATA_WIDTH:0] = {1'b1, w_head};
            end
            (wb.adr_i == KB_REG_STATUS): begin
                w_rdata[CW-1:0]    = w_count;
                w_rdata[KB_ST_EMPTY] = w_empty;
                w_rdata[KB_ST_FULL]  = w_full;
                w_rdata[KB_ST_OVF]   = r_ovf;
            end
            (wb.adr_i == KB_REG_CTRL): begin
`ifdef WB_KB_FIFO_IRQ_EN
                w_rdata[KB_CTRL_IRQEN] = r_irq_en;
`endif
            end
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= 1'b0;
            r_dat <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_ack <= w_req;
            if (w_req) r_dat <= w_rd ? w_rdata : '0;
            r_ovf <= (r_ovf & ~w_clrovf) | w_drop;
        end
    end

`ifdef WB_KB_FIFO_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_irq_en <= wb.dat_i[KB_CTRL_IRQEN];
            r_irq <= r_irq_en & ~w_empty;
        end
    end

    assign irq = r_irq;
`endif

    assign wb.ack_o = r_ack;
    assign wb.dat_o = r_dat;

endmodule
